addsub_pipe: RTL and testbench

Parametrised, pipelined add-then-subtract unit. Each accepted transaction produces `(a + b) - c` with carry and borrow flags. An accumulate mode instead produces a running `acc + a - c`. The block replaces the fixed-width combinational add/subtract datapath with a registered two-stage engine that uses valid/ready handshakes on both sides, so it can sit between streaming producers and consumers in the arithmetic cluster.

---
 rtl/addsub_pipe.sv | 99 +++++++++
 tb/tb_addsub_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Two-stage valid/ready add-then-subtract engine with an accumulate mode.
// S1 holds the operand sum; S2 subtracts, owns the accumulator and holds the outputs.
module addsub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             borrow
);

    typedef enum logic {
        ADDSUB = 1'b0,
        ACCUM  = 1'b1
    } mode_e;

    logic             s1_valid;
    logic [WIDTH:0]   s1_sum;
    logic [WIDTH-1:0] s1_c;
    mode_e            s1_mode;
    logic [WIDTH-1:0] acc;

    logic             s2_en;
    logic             accept;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] nxt_result;
    logic             nxt_carry;
    logic             nxt_borrow;

    always_comb begin
        s2_en    = s1_valid && (!out_valid || out_ready);
        in_ready = !s1_valid || s2_en;
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_c     <= '0;
            s1_mode  <= ADDSUB;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_sum   <= (mode_e'(mode) == ACCUM) ? {1'b0, a} : ({1'b0, a} + {1'b0, b});
            s1_c     <= c;
            s1_mode  <= mode_e'(mode);
        end else if (s2_en) begin
            s1_valid <= 1'b0;
        end
    end

    // Low WIDTH bits of the difference equal the WIDTH+2-bit difference modulo 2^WIDTH;
    // the sign is taken from the unsigned compare instead.
    always_comb begin
        acc_eff    = acc_clr ? '0 : acc;
        t          = (s1_mode == ACCUM) ? ({1'b0, acc_eff} + {1'b0, s1_sum[WIDTH-1:0]}) : s1_sum;
        nxt_result = t[WIDTH-1:0] - s1_c;
        nxt_carry  = t[WIDTH];
        nxt_borrow = t < {1'b0, s1_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            borrow    <= 1'b0;
        end else if (s2_en) begin
            out_valid <= 1'b1;
            result    <= nxt_result;
            carry     <= nxt_carry;
            borrow    <= nxt_borrow;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (s2_en && s1_mode == ACCUM) begin
            acc <= nxt_result;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed test-plan steps plus randomized
// traffic, scored against a plain-arithmetic reference model.
module tb_addsub_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] c = '0;
    logic         acc_clr = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry;
    logic         borrow;

    addsub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .c         (c),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W+1:0] rcb;
        int           t;
    } exp_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           last_lat = 0;
    exp_t         exp_q[$];
    logic [W+1:0] log_q[$];
    logic [W-1:0] model_acc = '0;
    logic [W+1:0] held = '0;
    logic         hold_armed = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: unbounded integer arithmetic, then reduced to the port widths.
    task automatic push_exp(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] z);
        longint       s, d;
        logic [W-1:0] r;
        logic         cy, bw;
        exp_t         e;
        s  = m ? (longint'(model_acc) + longint'(x)) : (longint'(x) + longint'(y));
        cy = (s >= (longint'(1) << W));
        d  = s - longint'(z);
        bw = (d < 0);
        r  = W'(d);
        if (m) model_acc = r;
        e.rcb = {r, cy, bw};
        e.t   = cyc;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard", 32'({result, carry, borrow}), 32'(e.rcb));
                    last_lat = cyc - e.t;
                    log_q.push_back({result, carry, borrow});
                end
            end
            if (out_valid && !out_ready) begin
                if (hold_armed) check("hold_stable", 32'({result, carry, borrow}), 32'(held));
                held       = {result, carry, borrow};
                hold_armed = 1'b1;
            end else begin
                hold_armed = 1'b0;
            end
        end else begin
            hold_armed = 1'b0;
        end
    end

    task automatic drive(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] z);
        mode = m; a = x; b = y; c = z; in_valid = 1'b1;
    endtask

    task automatic send(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] z);
        logic ok;
        ok = 1'b0;
        drive(m, x, y, z);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(m, x, y, z);
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clr_pulse();
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr   = 1'b0;
        model_acc = '0;
    endtask

    function automatic logic [W+1:0] back(input int n);
        return log_q[log_q.size() - n];
    endfunction

    logic [W-1:0] bp_a[4], bp_b[4], bp_c[4];
    logic [W+1:0] r;
    logic [W-1:0] snap;
    int           idx, n0, st;

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_outputs", 32'({out_valid, result, carry, borrow}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic ADDSUB and latency
        out_ready = 1'b1;
        send(1'b0, 16'd100, 16'd50, 16'd30);
        drain();
        r = back(1);
        check("basic_result", 32'(r[W+1:2]), 32'd120);
        check("basic_flags", 32'(r[1:0]), 32'd0);
        check("basic_latency", 32'(last_lat), 32'd2);

        // Carry and borrow
        send(1'b0, 16'hFFFF, 16'd2, 16'd0);
        send(1'b0, 16'd5, 16'd3, 16'd10);
        drain();
        check("carry_case", 32'(back(2)), 32'({16'h0001, 1'b1, 1'b0}));
        check("borrow_case", 32'(back(1)), 32'({16'hFFFE, 1'b0, 1'b1}));

        // Accumulate with clear
        clr_pulse();
        for (int i = 0; i < 3; i++) send(1'b1, 16'd10, 16'd0, 16'd3);
        drain();
        r = back(3); check("accum_1", 32'(r[W+1:2]), 32'd7);
        r = back(2); check("accum_2", 32'(r[W+1:2]), 32'd14);
        r = back(1); check("accum_3", 32'(r[W+1:2]), 32'd21);
        acc_clr   = 1'b1;
        model_acc = '0;
        send(1'b1, 16'd4, 16'd0, 16'd1);
        @(posedge clk); #1;
        acc_clr = 1'b0;
        drain();
        r = back(1); check("accum_clr_same", 32'(r[W+1:2]), 32'd3);

        // Backpressure
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = W'($urandom); bp_b[i] = W'($urandom); bp_c[i] = W'($urandom);
        end
        out_ready = 1'b0;
        idx = 0;
        drive(1'b0, bp_a[0], bp_b[0], bp_c[0]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                push_exp(1'b0, bp_a[idx], bp_b[idx], bp_c[idx]);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 4) drive(1'b0, bp_a[idx], bp_b[idx], bp_c[idx]);
            else in_valid = 1'b0;
        end
        check("bp_accepted", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        snap = result;
        repeat (2) @(negedge clk);
        check("bp_result_stable", 32'(result), 32'(snap));
        @(posedge clk); #1;
        out_ready = 1'b1;
        n0 = log_q.size();
        st = cyc;
        for (int i = 0; i < 20 && idx < 4; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                push_exp(1'b0, bp_a[idx], bp_b[idx], bp_c[idx]);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 4) drive(1'b0, bp_a[idx], bp_b[idx], bp_c[idx]);
            else in_valid = 1'b0;
        end
        for (int i = 0; i < 20 && log_q.size() < n0 + 4; i++) begin
            @(posedge clk); #1;
        end
        check("bp_release_cycles", 32'(cyc - st), 32'd4);
        drain();

        // Mode interleave
        clr_pulse();
        send(1'b1, 16'd10, 16'd0, 16'd0);
        send(1'b0, 16'd1, 16'd1, 16'd1);
        send(1'b1, 16'd5, 16'd0, 16'd0);
        drain();
        r = back(3); check("mix_1", 32'(r[W+1:2]), 32'd10);
        r = back(2); check("mix_2", 32'(r[W+1:2]), 32'd1);
        r = back(1); check("mix_3", 32'(r[W+1:2]), 32'd15);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            mode      = $urandom % 2;
            a         = W'($urandom);
            b         = W'($urandom);
            c         = ($urandom % 2) ? W'($urandom) : W'($urandom % 64);
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            if (in_valid && in_ready) push_exp(mode, a, b, c);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset mid-operation
        clr_pulse();
        for (int i = 0; i < 3; i++) send(1'b1, 16'd10, 16'd0, 16'd3);
        drain();
        r = back(1); check("pre_reset_acc", 32'(r[W+1:2]), 32'd21);
        out_ready = 1'b0;
        send(1'b0, 16'd7, 16'd8, 16'd9);
        send(1'b1, 16'd2, 16'd0, 16'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        model_acc = '0;
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(1'b1, 16'd1, 16'd0, 16'd0);
        drain();
        r = back(1); check("post_reset_accum", 32'(r[W+1:2]), 32'd1);

        check("final_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
